// File: rtl/mem_rf2r.sv
`default_nettype none
// ============================================================================
// mem_rf2r : 1-write / 2-read register file, lane-masked write, write-first
//            bypass, out-of-range detection with sticky ERR.
// Revision : 1.0
// ============================================================================
module mem_rf2r #(
    parameter int WIDTH  = 16,
    parameter int LANE   = 8,
    parameter int SIZE_E = 4,
    parameter int DEPTH  = 2**SIZE_E
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    WRITE,
    input  logic [SIZE_E-1:0]       iWRAddr,
    input  logic [WIDTH/LANE-1:0]   iWRMask,
    input  logic [WIDTH-1:0]        D,
    input  logic                    READA,
    input  logic [SIZE_E-1:0]       iRDAddrA,
    input  logic                    READB,
    input  logic [SIZE_E-1:0]       iRDAddrB,
    output logic [WIDTH-1:0]        QA,
    output logic [WIDTH-1:0]        QB,
    output logic                    QA_VALID,
    output logic                    QB_VALID,
    input  logic                    CLR_ERR,
    output logic                    ERR
);

    localparam int                NLANE   = WIDTH / LANE;
    localparam logic [SIZE_E:0]   DEPTH_W = (SIZE_E+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] lane_bits;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;
    logic             wr_in_range;
    logic             ra_in_range;
    logic             rb_in_range;
    logic             err_set;

    genvar k;
    generate
        for (k = 0; k < NLANE; k++) begin : g_lane
            assign lane_bits[k*LANE +: LANE] = {LANE{iWRMask[k]}};
        end
    endgenerate

    // Extra MSB so DEPTH == 2**SIZE_E compares correctly (nothing out of range).
    assign wr_in_range = {1'b0, iWRAddr}  < DEPTH_W;
    assign ra_in_range = {1'b0, iRDAddrA} < DEPTH_W;
    assign rb_in_range = {1'b0, iRDAddrB} < DEPTH_W;

    assign err_set = (WRITE && !wr_in_range) ||
                     (READA && !ra_in_range) ||
                     (READB && !rb_in_range);

    // Read muxes only match implemented entries, so out-of-range reads give 0.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (iRDAddrA == SIZE_E'(e)) rd_a = mem[e];
            if (iRDAddrB == SIZE_E'(e)) rd_b = mem[e];
        end
        if (WRITE && wr_in_range && iWRAddr == iRDAddrA)
            rd_a = (rd_a & ~lane_bits) | (D & lane_bits);
        if (WRITE && wr_in_range && iWRAddr == iRDAddrB)
            rd_b = (rd_b & ~lane_bits) | (D & lane_bits);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (WRITE && iWRAddr == SIZE_E'(e))
                    mem[e] <= (mem[e] & ~lane_bits) | (D & lane_bits);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            QA       <= '0;
            QB       <= '0;
            QA_VALID <= 1'b0;
            QB_VALID <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            QA_VALID <= READA;
            QB_VALID <= READB;
            if (READA) QA <= rd_a;
            if (READB) QB <= rd_b;
            if (err_set)
                ERR <= 1'b1;
            else if (CLR_ERR)
                ERR <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_rf2r.sv
`default_nettype none
// ============================================================================
// tb_mem_rf2r : directed self-checking bench for mem_rf2r (DEPTH=12).
// Revision    : 1.0
// ============================================================================
module tb_mem_rf2r;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        WRITE = 1'b0;
    logic [3:0]  iWRAddr = '0;
    logic [1:0]  iWRMask = '0;
    logic [15:0] D = '0;
    logic        READA = 1'b0;
    logic [3:0]  iRDAddrA = '0;
    logic        READB = 1'b0;
    logic [3:0]  iRDAddrB = '0;
    logic [15:0] QA;
    logic [15:0] QB;
    logic        QA_VALID;
    logic        QB_VALID;
    logic        CLR_ERR = 1'b0;
    logic        ERR;

    int tests = 0;
    int fails = 0;

    mem_rf2r #(.WIDTH(16), .LANE(8), .SIZE_E(4), .DEPTH(12)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .WRITE(WRITE), .iWRAddr(iWRAddr), .iWRMask(iWRMask), .D(D),
        .READA(READA), .iRDAddrA(iRDAddrA),
        .READB(READB), .iRDAddrB(iRDAddrB),
        .QA(QA), .QB(QB), .QA_VALID(QA_VALID), .QB_VALID(QB_VALID),
        .CLR_ERR(CLR_ERR), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WRITE = 1'b0; READA = 1'b0; READB = 1'b0; CLR_ERR = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
        WRITE = 1'b1; iWRAddr = a; D = d; iWRMask = m;
    endtask

    task automatic test_reset();
        wr(4'd0, 16'h1111, 2'b11); READB = 1'b1; iRDAddrB = 4'd14;
        tick(); idle();
        READA = 1'b1; iRDAddrA = 4'd0;
        tick(); idle();
        tests++;
        if (QA !== 16'h1111 || ERR !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset: QA=%h ERR=%b, required QA=1111 ERR=1", QA, ERR);
        end
        #2 RST_N = 1'b0;
        #1;
        tests++;
        if (QA !== 16'h0 || QA_VALID !== 1'b0 || ERR !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: QA=%h QA_VALID=%b ERR=%b, required 0000/0/0", QA, QA_VALID, ERR);
        end
        tick();
        RST_N = 1'b1;
        for (int a = 0; a < 12; a++) begin
            READA = 1'b1; iRDAddrA = 4'(a);
            tick();
            tests++;
            if (QA !== 16'h0 || QA_VALID !== 1'b1 || ERR !== 1'b0) begin
                fails++;
                $display("FAIL reset_contents[%0d]: QA=%h V=%b ERR=%b, required 0000/1/0", a, QA, QA_VALID, ERR);
            end
        end
        idle();
        tick();
        tests++;
        if (QA_VALID !== 1'b0) begin
            fails++;
            $display("FAIL valid_drop: QA_VALID=%b, required 0", QA_VALID);
        end
    endtask

    task automatic test_masked_write();
        wr(4'd3, 16'hA55A, 2'b11); tick();
        wr(4'd3, 16'h00FF, 2'b01); tick();
        wr(4'd4, 16'h7777, 2'b00); tick();
        idle();
        READB = 1'b1; iRDAddrB = 4'd3; tick();
        tests++;
        if (QB !== 16'hA5FF || QB_VALID !== 1'b1) begin
            fails++;
            $display("FAIL masked_write: QB=%h V=%b, required A5FF/1", QB, QB_VALID);
        end
        iRDAddrB = 4'd4; tick(); idle();
        tests++;
        if (QB !== 16'h0000) begin
            fails++;
            $display("FAIL zero_mask_noop: QB=%h, required 0000", QB);
        end
    endtask

    task automatic test_bypass();
        wr(4'd5, 16'h1234, 2'b11); tick();
        wr(4'd5, 16'hBEEF, 2'b10);
        READA = 1'b1; iRDAddrA = 4'd5; READB = 1'b1; iRDAddrB = 4'd5;
        tick(); idle();
        tests++;
        if (QA !== 16'hBE34 || QB !== 16'hBE34 || QA_VALID !== 1'b1 || QB_VALID !== 1'b1) begin
            fails++;
            $display("FAIL bypass: QA=%h QB=%h, required BE34 on both with VALID", QA, QB);
        end
        tick();
        READA = 1'b1; iRDAddrA = 4'd5; tick(); idle();
        tests++;
        if (QA !== 16'hBE34) begin
            fails++;
            $display("FAIL bypass_stored: QA=%h, required BE34", QA);
        end
    endtask

    task automatic test_out_of_range();
        for (int a = 0; a < 12; a++) begin
            wr(4'(a), 16'h0100 + 16'(a), 2'b11); tick();
        end
        idle();
        tests++;
        if (ERR !== 1'b0) begin
            fails++;
            $display("FAIL err_idle: ERR=%b, required 0", ERR);
        end
        wr(4'd12, 16'hFFFF, 2'b11); tick(); idle();
        tests++;
        if (ERR !== 1'b1) begin
            fails++;
            $display("FAIL oor_write_err: ERR=%b, required 1", ERR);
        end
        for (int a = 0; a < 12; a++) begin
            READA = 1'b1; iRDAddrA = 4'(a); tick();
            tests++;
            if (QA !== 16'h0100 + 16'(a)) begin
                fails++;
                $display("FAIL oor_no_alias[%0d]: QA=%h, required %h", a, QA, 16'h0100 + 16'(a));
            end
        end
        iRDAddrA = 4'd15; tick(); idle();
        tests++;
        if (QA !== 16'h0000 || QA_VALID !== 1'b1 || ERR !== 1'b1) begin
            fails++;
            $display("FAIL oor_read: QA=%h V=%b ERR=%b, required 0000/1/1", QA, QA_VALID, ERR);
        end
    endtask

    task automatic test_err_priority();
        CLR_ERR = 1'b1; tick(); idle();
        tests++;
        if (ERR !== 1'b0) begin
            fails++;
            $display("FAIL err_clear: ERR=%b, required 0", ERR);
        end
        READB = 1'b1; iRDAddrB = 4'd0; tick();
        CLR_ERR = 1'b1; iRDAddrB = 4'd13; tick(); idle();
        tests++;
        if (ERR !== 1'b1 || QB !== 16'h0000 || QB_VALID !== 1'b1) begin
            fails++;
            $display("FAIL err_set_wins: ERR=%b QB=%h V=%b, required 1/0000/1", ERR, QB, QB_VALID);
        end
        tick();
        tests++;
        if (ERR !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: ERR=%b, required 1", ERR);
        end
        CLR_ERR = 1'b1; tick(); idle();
    endtask

    task automatic test_hold_valid();
        wr(4'd2, 16'h0042, 2'b11); tick(); idle();
        READA = 1'b1; iRDAddrA = 4'd2; READB = 1'b1; iRDAddrB = 4'd7; tick(); idle();
        tests++;
        if (QA !== 16'h0042 || QA_VALID !== 1'b1 || QB !== 16'h0107) begin
            fails++;
            $display("FAIL dual_read: QA=%h V=%b QB=%h, required 0042/1/0107", QA, QA_VALID, QB);
        end
        wr(4'd2, 16'h9999, 2'b11);
        for (int c = 0; c < 3; c++) begin
            tick(); idle();
            tests++;
            if (QA !== 16'h0042 || QA_VALID !== 1'b0 || QB !== 16'h0107 || QB_VALID !== 1'b0) begin
                fails++;
                $display("FAIL hold[%0d]: QA=%h V=%b QB=%h, required 0042/0/0107", c, QA, QA_VALID, QB);
            end
        end
        READA = 1'b1; iRDAddrA = 4'd2; tick(); idle();
        tests++;
        if (QA !== 16'h9999 || QA_VALID !== 1'b1) begin
            fails++;
            $display("FAIL reread: QA=%h V=%b, required 9999/1", QA, QA_VALID);
        end
    endtask

    initial begin
        RST_N = 1'b0;
        tick(); tick();
        RST_N = 1'b1;
        tick();
        test_reset();
        test_masked_write();
        test_bypass();
        test_out_of_range();
        test_err_priority();
        test_hold_valid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
